// File: rtl/noc_cdc_tx.sv
// noc_cdc_tx: source side of a toggle req/ack clock-domain crossing.
// Define NOC_CDC_TX_TIMEOUT_EN to add the sticky ack-wait timeout (err_o/err_clr_i).
module noc_cdc_tx #(
    parameter int WIDTH          = 32,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             src_ready_o,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             busy_o
`ifdef NOC_CDC_TX_TIMEOUT_EN
    ,
    output logic             err_o,
    input  logic             err_clr_i
`endif
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_BUSY
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(SYNC_STAGES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_nxt;
    logic                   r_req;
    logic                   w_req_nxt;
    logic [WIDTH-1:0]       r_data;
    logic [WIDTH-1:0]       w_data_nxt;
    logic                   w_ack_s;
    logic                   w_accept;

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    assign w_accept = src_valid_i && (r_state == S_IDLE);

    // cdc_ack_i feeds the first flop directly; nothing in front of it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cdc_ack_i};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        unique case (r_state)
            S_INIT: begin
                // hold off until the synchronizer has been flushed
                if (r_cnt == CNT_LAST) begin
                    if (w_ack_s == r_req) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_data_nxt  = src_data_i;
                    w_req_nxt   = ~r_req;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_ack_s == r_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    assign src_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state == S_BUSY);
    assign cdc_req_o   = r_req;
    assign cdc_data_o  = r_data;

`ifdef NOC_CDC_TX_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wcnt;
    logic [15:0] w_wcnt_inc;
    logic        r_err;
    logic        w_hit;

    assign w_wcnt_inc = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
    // fire once, on the edge the count first lands on the limit
    assign w_hit = (r_state == S_BUSY) && (w_wcnt_inc == TMO) && (r_wcnt != TMO);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wcnt <= '0;
        end else if (w_accept) begin
            r_wcnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_wcnt <= w_wcnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_hit) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_noc_cdc_tx.sv
// tb_noc_cdc_tx: randomized bench for noc_cdc_tx with a destination-side model.
// Timeout scenario runs only when NOC_CDC_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_noc_cdc_tx;

    localparam int W        = 32;
    localparam int SS       = 3;
    localparam int TMO      = 8;
    localparam int ECHO_DLY = 5;

    logic         clk       = 1'b0;
    logic         rstn      = 1'b0;
    logic         src_valid = 1'b0;
    logic [W-1:0] src_data  = '0;
    logic         src_ready;
    logic         cdc_req;
    logic [W-1:0] cdc_data;
    logic         cdc_ack;
    logic         busy;
    logic         man_ack   = 1'b0;
    logic         echo_en   = 1'b0;
    logic         echo_ack  = 1'b0;
    logic         exp_req   = 1'b0;
`ifdef NOC_CDC_TX_TIMEOUT_EN
    logic         err;
    logic         err_clr   = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    assign cdc_ack = echo_en ? echo_ack : man_ack;

    always #5 clk = ~clk;

    noc_cdc_tx #(
        .WIDTH(W),
        .SYNC_STAGES(SS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .src_valid_i(src_valid),
        .src_data_i(src_data),
        .src_ready_o(src_ready),
        .cdc_req_o(cdc_req),
        .cdc_data_o(cdc_data),
        .cdc_ack_i(cdc_ack),
        .busy_o(busy)
`ifdef NOC_CDC_TX_TIMEOUT_EN
        ,
        .err_o(err),
        .err_clr_i(err_clr)
`endif
    );

    // destination model: capture on req toggle, echo after ECHO_DLY cycles
    logic         seen_req = 1'b0;
    int           cd       = 0;
    logic [W-1:0] cap_q[$];

    always @(negedge clk) begin
        if (!rstn) begin
            seen_req = 1'b0;
            cd       = 0;
            echo_ack = 1'b0;
        end else if (echo_en) begin
            if (cdc_req !== seen_req) begin
                seen_req = cdc_req;
                cap_q.push_back(cdc_data);
                cd = ECHO_DLY;
            end else begin
                if (busy && cap_q.size() > 0) begin
                    total++;
                    if (cdc_data !== cap_q[$]) begin
                        bad++;
                        $display("FAIL hold: cdc_data=%h want %h", cdc_data, cap_q[$]);
                    end
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) echo_ack = seen_req;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rstn      = 1'b0;
        src_valid = 1'b0;
        man_ack   = 1'b0;
        echo_en   = 1'b0;
        exp_req   = 1'b0;
`ifdef NOC_CDC_TX_TIMEOUT_EN
        err_clr   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_ready(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n = i + 1;
            if (src_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_word(input logic [W-1:0] w);
        src_valid = 1'b1;
        src_data  = w;
        @(negedge clk);
        src_valid = 1'b0;
        src_data  = $urandom;
        exp_req   = ~exp_req;
    endtask

    task automatic test_reset();
        bit exp_rdy;
        rstn    = 1'b0;
        man_ack = 1'b0;
        exp_req = 1'b0;
        #1;
        total++;
        if (cdc_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", cdc_req); end
        total++;
        if (cdc_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", cdc_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_rdy = (k >= SS);
            total++;
            if (src_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rst_ready edge%0d: got %b want %b", k, src_ready, exp_rdy);
            end
        end
        total++;
        if (cdc_req !== 1'b0 || cdc_data !== '0) begin
            bad++;
            $display("FAIL rst_idle: req=%b data=%h want 0/0", cdc_req, cdc_data);
        end
    endtask

    task automatic test_single();
        int d;
        bit exp_rdy;
        drive_word(32'hDEADBEEF);
        total++;
        if (cdc_req !== exp_req) begin bad++; $display("FAIL single_req: got %b want %b", cdc_req, exp_req); end
        total++;
        if (cdc_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", cdc_data); end
        total++;
        if (busy !== 1'b1 || src_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_busy: busy=%b ready=%b want 1/0", busy, src_ready);
        end
        d = $urandom_range(0, 4);
        repeat (d) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL single_wait: busy=%b want 1", busy); end
        end
        man_ack = exp_req;
        for (int k = 0; k <= SS; k++) begin
            @(negedge clk);
            exp_rdy = (k == SS);
            total++;
            if (src_ready !== exp_rdy) begin
                bad++;
                $display("FAIL ack_latency M+%0d: ready=%b want %b", k, src_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] w;
        bit ok;
        int n;
        w = $urandom | 32'h1;
        drive_word(w);
        src_valid = 1'b1;
        src_data  = '0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (cdc_data !== w || cdc_req !== exp_req) begin
                bad++;
                $display("FAIL busy_ignore: data=%h req=%b want %h/%b", cdc_data, cdc_req, w, exp_req);
            end
        end
        src_valid = 1'b0;
        man_ack   = exp_req;
        wait_ready(ok, n);
        total++;
        if (!ok || cdc_data !== w) begin
            bad++;
            $display("FAIL busy_exit: ready_ok=%b data=%h want 1/%h", ok, cdc_data, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sent_q[$];
        logic [W-1:0] w;
        bit ok;
        int n;
        do_reset();
        cap_q.delete();
        echo_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            w = (i < 3) ? W'(i + 1) : W'($urandom);
            wait_ready(ok, n);
            total++;
            if (!ok) begin bad++; $display("FAIL b2b_ready%0d: timed out", i); end
            if (i > 0) begin
                total++;
                if (n !== ECHO_DLY + SS + 1) begin
                    bad++;
                    $display("FAIL b2b_cycles%0d: got %0d want %0d", i, n, ECHO_DLY + SS + 1);
                end
            end
            drive_word(w);
            sent_q.push_back(w);
            total++;
            if (cdc_req !== exp_req) begin
                bad++;
                $display("FAIL b2b_req%0d: got %b want %b", i, cdc_req, exp_req);
            end
        end
        wait_ready(ok, n);
        total++;
        if (cap_q.size() != sent_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), sent_q.size());
        end else begin
            foreach (sent_q[i]) begin
                total++;
                if (cap_q[i] !== sent_q[i]) begin
                    bad++;
                    $display("FAIL b2b_word%0d: got %h want %h", i, cap_q[i], sent_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w2;
        bit ok;
        int n;
        do_reset();
        wait_ready(ok, n);
        drive_word($urandom);
        repeat (2) @(negedge clk);
        man_ack = exp_req;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (cdc_req !== 1'b0 || cdc_data !== '0 || busy !== 1'b0 || src_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst: req=%b data=%h busy=%b rdy=%b want all 0",
                     cdc_req, cdc_data, busy, src_ready);
        end
        man_ack = 1'b0;
        exp_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(ok, n);
        total++;
        if (!ok) begin bad++; $display("FAIL mid_rel: ready timed out"); end
        w2 = $urandom;
        drive_word(w2);
        total++;
        if (cdc_req !== 1'b1 || cdc_data !== w2) begin
            bad++;
            $display("FAIL mid_xfer: req=%b data=%h want 1/%h", cdc_req, cdc_data, w2);
        end
        man_ack = exp_req;
        wait_ready(ok, n);
        total++;
        if (!ok || n !== SS + 1) begin
            bad++;
            $display("FAIL mid_done: ok=%b cycles=%0d want 1/%0d", ok, n, SS + 1);
        end
    endtask

`ifdef NOC_CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit exp_err;
        int n;
        do_reset();
        wait_ready(ok, n);
        drive_word($urandom);
        for (int k = 1; k <= TMO + 2; k++) begin
            @(negedge clk);
            exp_err = (k >= TMO);
            total++;
            if (err !== exp_err || busy !== 1'b1) begin
                bad++;
                $display("FAIL tmo_cyc%0d: err=%b busy=%b want %b/1", k, err, busy, exp_err);
            end
        end
        man_ack = exp_req;
        wait_ready(ok, n);
        total++;
        if (!ok || err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky: ok=%b err=%b want 1/1", ok, err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL tmo_clr: err=%b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef NOC_CDC_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_cdc_tx.md
Name: noc_cdc_tx

Overview:
- Source-domain transmitter of a toggle-based req/ack clock-domain-crossing handshake for NoC sideband and config transfers.
- Accepts one WIDTH-bit word per transfer on a valid/ready interface and holds it stable on cdc_data_o.
- Flips cdc_req_o, then waits for the destination's returned ack toggle, which it brings in through an internal 3-flop synchronizer.
- Pairs with the destination-side receiver, which synchronizes cdc_req_o, captures cdc_data_o, and echoes the toggle on cdc_ack_i.

Parameters:
- WIDTH, 32, payload width in bits.
- SYNC_STAGES, 3, number of flops in the ack synchronizer; legal values 2..4.
- TIMEOUT_CYCLES, 1024, ack-wait limit in clk cycles; used only with the optional feature; legal values 2..65535.

Ports:
- clk  input  1  source-domain clock.
- rstn  input  1  reset, asynchronous, active-low.
- src_valid_i  input  1  source has a word to send.
- src_data_i  input  WIDTH  word to send; sampled only on accept.
- src_ready_o  output  1  block can accept a word.
- cdc_req_o  output  1  request toggle to the destination domain; registered.
- cdc_data_o  output  WIDTH  held payload to the destination domain; registered.
- cdc_ack_i  input  1  ack toggle from the destination domain; asynchronous to clk.
- busy_o  output  1  a transfer is outstanding.

Behaviour:
- Reset (rstn low):
  - State is INIT; cdc_req_o=0, cdc_data_o=0, src_ready_o=0, busy_o=0.
  - Synchronizer flops, stage counter and optional timeout logic are all cleared.
- Ack synchronizer:
  - SYNC_STAGES posedge flops, all reset to 0; ack_s is the last stage.
  - No logic sits between cdc_ack_i and the first flop.
- Accept: a word is accepted when src_valid_i && src_ready_o at a posedge.
- Outputs decode from registered state only:
  - src_ready_o = (state==IDLE).
  - busy_o = (state==BUSY).
- INIT state:
  - Counts SYNC_STAGES cycles after rstn deasserts to flush the synchronizer.
  - Moves to IDLE on the edge where the count reaches SYNC_STAGES-1 and ack_s==cdc_req_o.
  - Otherwise stays in INIT; the counter saturates.
- IDLE state: on accept, in the same edge:
  - cdc_data_o <= src_data_i;
  - cdc_req_o <= ~cdc_req_o;
  - state <= BUSY.
- BUSY state:
  - cdc_data_o and cdc_req_o are frozen.
  - src_valid_i and src_data_i are ignored.
  - Moves to IDLE on the first edge where ack_s==cdc_req_o.
- Latency from ack toggle to ready:
  - cdc_ack_i toggles before edge M; ack_s reflects it after edge M+SYNC_STAGES-1.
  - state becomes IDLE at edge M+SYNC_STAGES, so src_ready_o rises after edge M+3 at default.
- Back-to-back transfers: accepting on the first IDLE cycle is legal; minimum spacing is 1 IDLE cycle between transfers.
- cdc_data_o holding rule: it changes only on the accept edge, and is held from that edge until the next accept. The destination samples it only after seeing the req toggle.
- Wrap-around: cdc_req_o is 1 bit and toggles indefinitely; there is no sequence counter.
- Spurious ack:
  - An ack_s change while in IDLE or INIT has no effect beyond the equality check.
  - An ack_s that was already equal at BUSY entry cannot happen by protocol. If it does, BUSY exits on the next edge.
- Reset mid-transfer:
  - Asynchronous return to the reset values above; the pending word is dropped.
  - The destination must be reset in the same reset domain; no cross-reset recovery is provided.
- Simultaneous accept and ack change in IDLE: the accept proceeds normally, and the ack is evaluated against the new cdc_req_o from the next edge on.

Optional Feature:
- Macro: NOC_CDC_TX_TIMEOUT_EN.
- When defined:
  - Adds ports err_o (output, 1) and err_clr_i (input, 1), plus a 16-bit wait counter.
  - The counter resets to 0 on every accept and increments each BUSY cycle, saturating at 16'hFFFF.
  - When the counter reaches TIMEOUT_CYCLES while in BUSY, err_o is set (sticky); the state stays BUSY, with no abort and no retransmit.
  - err_clr_i=1 clears err_o on the next edge. If set and clear coincide, set wins.
  - err_o resets to 0.
- When undefined: no extra ports, no counter, and timing is identical in every other respect.

Test Plan:
- Reset release with cdc_ack_i=0 -> src_ready_o=0 for 3 edges, then 1; cdc_req_o=0, cdc_data_o=0.
- Accept 32'hDEADBEEF at edge N -> after edge N: cdc_req_o=1, cdc_data_o=32'hDEADBEEF, busy_o=1, src_ready_o=0. Bench toggles cdc_ack_i to 1 before edge M -> src_ready_o=1 after edge M+3.
- Three back-to-back words 1,2,3 with an auto-echo ack delay of 5 cycles -> cdc_req_o toggles 1,0,1. cdc_data_o is stable throughout each BUSY window, and no word is lost or duplicated.
- During BUSY, change src_data_i to 32'h0 while src_valid_i=1 -> cdc_data_o unchanged and no extra req toggle.
- Assert rstn low in BUSY mid-synchronizer -> all outputs return to their reset values immediately; after release, a new transfer completes normally.
- With NOC_CDC_TX_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack withheld -> err_o=1 on the 8th BUSY cycle. A later ack returns the block to IDLE with err_o still 1; err_clr_i pulse -> err_o=0.
